blink_decoder: RTL

Receive-side counterpart of the blinking state machine. It samples a blinking line once per sample tick, typically the 1 Hz divided clock presented as an enable, and measures each ON run and the OFF run that follows. For every completed ON/OFF pair it reports both lengths and counts blinks. A long OFF run is treated as end-of-sequence.

---
 rtl/blink_decoder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/blink_decoder.sv
// Blink decoder: samples a blinking line on each tick and measures ON/OFF
// run lengths. Each completed ON/OFF pair is published with a one-cycle
// valid pulse. A long OFF run ends the sequence: it is published with
// off_len=0 and a done pulse.
module blink_decoder #(
  parameter int CNT_W      = 4,
  parameter int IDLE_TICKS = 8,
  parameter int BCNT_W     = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_tick,
  input  logic              i_in,
  input  logic              i_clear,
  output logic              o_valid,
  output logic [CNT_W-1:0]  o_on_len,
  output logic [CNT_W-1:0]  o_off_len,
  output logic              o_done,
  output logic [BCNT_W-1:0] o_blink_count,
  output logic              o_err,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   IDLE_T  = (CNT_W+1)'(IDLE_TICKS);

  state_t            state, state_n;
  logic [CNT_W-1:0]  run, run_n;
  logic [CNT_W-1:0]  on_len, on_len_n;
  logic [CNT_W-1:0]  on_out_n, off_out_n;
  logic [BCNT_W-1:0] bcnt_n;
  logic              valid_n, done_n, err_n;
  logic [CNT_W:0]    run_p1;
  logic [BCNT_W-1:0] bcnt_inc;

  // run_p1 is one bit wider so the idle compare cannot wrap.
  assign run_p1   = {1'b0, run} + 1'b1;
  assign bcnt_inc = (o_blink_count == {BCNT_W{1'b1}}) ? o_blink_count
                                                      : o_blink_count + 1'b1;

  // Register state, counters and all outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= S_IDLE;
      run           <= '0;
      on_len        <= '0;
      o_valid       <= 1'b0;
      o_done        <= 1'b0;
      o_on_len      <= '0;
      o_off_len     <= '0;
      o_blink_count <= '0;
      o_err         <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      state         <= state_n;
      run           <= run_n;
      on_len        <= on_len_n;
      o_valid       <= valid_n;
      o_done        <= done_n;
      o_on_len      <= on_out_n;
      o_off_len     <= off_out_n;
      o_blink_count <= bcnt_n;
      o_err         <= err_n;
      o_busy        <= (state_n != S_IDLE);
    end
  end

  // Next state: clear beats tick; pulses drop on any non-publishing cycle.
  always_comb begin
    state_n   = state;
    run_n     = run;
    on_len_n  = on_len;
    on_out_n  = o_on_len;
    off_out_n = o_off_len;
    bcnt_n    = o_blink_count;
    err_n     = o_err;
    valid_n   = 1'b0;
    done_n    = 1'b0;
    if (i_clear) begin
      state_n   = S_IDLE;
      run_n     = '0;
      on_len_n  = '0;
      on_out_n  = '0;
      off_out_n = '0;
      bcnt_n    = '0;
      err_n     = 1'b0;
    end else if (i_tick) begin
      case (state)
        S_IDLE: begin
          if (i_in) begin
            run_n   = CNT_W'(1);
            state_n = S_ON;
          end
        end
        S_ON: begin
          if (i_in) begin
            // Saturate the ON run and flag it; the flag is sticky.
            if (run == RUN_MAX) err_n = 1'b1;
            else                run_n = run + 1'b1;
          end else begin
            on_len_n = run;
            run_n    = CNT_W'(1);
            state_n  = S_OFF;
          end
        end
        S_OFF: begin
          if (i_in) begin
            on_out_n  = on_len;
            off_out_n = run;
            valid_n   = 1'b1;
            bcnt_n    = bcnt_inc;
            run_n     = CNT_W'(1);
            state_n   = S_ON;
          end else if (run_p1 == IDLE_T) begin
            // Idle timeout: publish the last blink with off_len=0.
            on_out_n  = on_len;
            off_out_n = '0;
            valid_n   = 1'b1;
            done_n    = 1'b1;
            bcnt_n    = bcnt_inc;
            run_n     = '0;
            state_n   = S_IDLE;
          end else begin
            run_n = run_p1[CNT_W-1:0];
          end
        end
        default: begin
          state_n = S_IDLE;
          run_n   = '0;
        end
      endcase
    end
  end

endmodule
